// File: rtl/n_bit_m_wide_shift_reg.sv
// M-stage, N-bit-wide word shift register: one word enters per clock and
// leaves M clocks later; Clr clears every stage asynchronously.
module n_bit_m_wide_shift_reg #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic         Clk,
    input  logic         Clr,
    input  logic [N-1:0] SI,
    output logic [N-1:0] SO
);

    generate
        if (N < 1 || M < 1) begin : g_bad_params
            $fatal(1, "n_bit_m_wide_shift_reg: N (%0d) and M (%0d) must both be >= 1", N, M);
        end
    endgenerate

    logic [N-1:0] temp [0:M-1];

    // NOTE: every stage is a real flop, so clearing the whole array on reset
    // is cheap; non-blocking updates make all stages move on the same edge.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            for (int i = 0; i < M; i++) begin
                temp[i] <= '0;
            end
        end else begin
            temp[0] <= SI;
            for (int i = 1; i < M; i++) begin
                temp[i] <= temp[i-1];
            end
        end
    end

    assign SO = temp[M-1];

endmodule

// File: tb/tb_n_bit_m_wide_shift_reg.sv
// Bench for n_bit_m_wide_shift_reg: three configurations (4x2, 8x1, 4x4) driven
// side by side and compared against a word-history model of each pipeline.
module tb_n_bit_m_wide_shift_reg;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [3:0] si_a, so_a;
    logic [7:0] si_b, so_b;
    logic [3:0] si_c, so_c;

    int checks = 0;
    int errors = 0;

    // Every word accepted since the last reset, oldest first.
    logic [3:0] hist_a[$];
    logic [7:0] hist_b[$];
    logic [3:0] hist_c[$];

    n_bit_m_wide_shift_reg #(.N(4), .M(2)) u_a (.Clk(clk), .Clr(clr_n), .SI(si_a), .SO(so_a));
    n_bit_m_wide_shift_reg #(.N(8), .M(1)) u_b (.Clk(clk), .Clr(clr_n), .SI(si_b), .SO(so_b));
    n_bit_m_wide_shift_reg #(.N(4), .M(4)) u_c (.Clk(clk), .Clr(clr_n), .SI(si_c), .SO(so_c));

    always #5 clk = ~clk;

    // Stage i holds the word accepted i shifts ago, or zero if fewer arrived.
    function automatic logic [3:0] exp_a(input int i);
        return (hist_a.size() > i) ? hist_a[hist_a.size()-1-i] : 4'h0;
    endfunction

    function automatic logic [7:0] exp_b(input int i);
        return (hist_b.size() > i) ? hist_b[hist_b.size()-1-i] : 8'h00;
    endfunction

    function automatic logic [3:0] exp_c(input int i);
        return (hist_c.size() > i) ? hist_c[hist_c.size()-1-i] : 4'h0;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " a.SO"}, {4'h0, so_a}, {4'h0, exp_a(1)});
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s a.temp[%0d]", tag, i), {4'h0, u_a.temp[i]}, {4'h0, exp_a(i)});
        end
        check({tag, " b.SO"}, so_b, exp_b(0));
        check({tag, " b.temp[0]"}, u_b.temp[0], exp_b(0));
        check({tag, " c.SO"}, {4'h0, so_c}, {4'h0, exp_c(3)});
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s c.temp[%0d]", tag, i), {4'h0, u_c.temp[i]}, {4'h0, exp_c(i)});
        end
    endtask

    // One rising edge; the model takes the inputs that were present at the edge.
    task automatic step(input string tag);
        @(posedge clk);
        #1;
        if (clr_n === 1'b1) begin
            hist_a.push_back(si_a);
            hist_b.push_back(si_b);
            hist_c.push_back(si_c);
        end
        check_all(tag);
    endtask

    // Assert Clr between edges and confirm the clear happens without a clock.
    task automatic drop_reset(input string tag);
        #2;
        clr_n = 1'b0;
        hist_a.delete();
        hist_b.delete();
        hist_c.delete();
        #1;
        check_all(tag);
    endtask

    logic [3:0] seq_a [8] = '{4'd1, 4'd2, 4'd3, 4'd8, 4'd8, 4'd8, 4'd14, 4'd8};
    logic [7:0] seq_b [8] = '{8'hA5, 8'hFF, 8'h3C, 8'h00, 8'h81, 8'h7E, 8'h01, 8'h80};

    initial begin
        clr_n = 1'b1;
        si_a  = 4'd15;
        si_b  = 8'hFF;
        si_c  = 4'd15;
        #1;
        drop_reset("reset_assert");

        for (int k = 0; k < 3; k++) begin
            step($sformatf("reset_hold%0d", k));
            check("reset_hold a.SO", {4'h0, so_a}, 8'h00);
        end

        // Release mid-cycle, then stream directed words into all three.
        #2;
        clr_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            si_a = seq_a[k];
            si_b = seq_b[k];
            si_c = 4'(k + 1);
            step($sformatf("stream_edge%0d", k + 1));
            if (k == 0) begin
                check("m2_edge1 SO", {4'h0, so_a}, 8'h00);
                check("m1_a5 SO", so_b, 8'hA5);
            end
            if (k == 1) begin
                check("m2_edge2 SO", {4'h0, so_a}, 8'h01);
                check("m1_ff SO", so_b, 8'hFF);
            end
            if (k == 3) check("m2_edge4 SO", {4'h0, so_a}, 8'h03);
            if (k >= 3) check($sformatf("m4_word%0d", k - 2), {4'h0, so_c}, 8'(k - 2));
        end

        // a now holds 14 (temp[1]) and 8 (temp[0]); clear mid-operation.
        drop_reset("midop_clear");
        check("midop_clear a.SO", {4'h0, so_a}, 8'h00);
        si_a = 4'd5;
        step("clr_low_edge");
        #2;
        clr_n = 1'b1;
        si_a = 4'd1;
        step("after_release1");
        si_a = 4'd0;
        step("after_release2");
        check("release_word SO", {4'h0, so_a}, 8'h01);

        // Constant input after reset release.
        drop_reset("const_clear");
        #2;
        clr_n = 1'b1;
        si_a = 4'd8;
        step("const_edge1");
        check("const_edge1 SO", {4'h0, so_a}, 8'h00);
        for (int k = 2; k <= 4; k++) begin
            step($sformatf("const_edge%0d", k));
            check("const SO", {4'h0, so_a}, 8'h08);
        end

        // All-ones and all-zeros through the deep pipeline.
        si_c = 4'd15;
        step("c_ones");
        si_c = 4'd0;
        for (int k = 0; k < 4; k++) step($sformatf("c_zeros%0d", k));
        check("c_ones_out", {4'h0, so_c}, 8'h00);

        // Unknown input travels like any other value.
        si_a = 4'bx;
        step("x_in");
        si_a = 4'd6;
        step("x_out");

        for (int k = 0; k < 40; k++) begin
            si_a = 4'($urandom);
            si_b = 8'($urandom);
            si_c = 4'($urandom);
            step($sformatf("rand%0d", k));
            if (k == 20) begin
                drop_reset("rand_clear");
                #2;
                clr_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
